// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between the producers, the round-robin arbiter and the FIFO.
// The master modport is the arbiter's view; slave is the producer/FIFO environment.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    ack;
  logic               fifo_full;
  logic               fifo_we;
  logic [DW-1:0]      fifo_data;
  logic               busy;

  modport master (
    input  req, req_data, fifo_full,
    output gnt, ack, fifo_we, fifo_data, busy
  );

  modport slave (
    output req, req_data, fifo_full,
    input  gnt, ack, fifo_we, fifo_data, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers, granting bounded bursts
// and stalling (with the grant held) while the FIFO reports full.
module fifo_wr_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input logic               clk,
  input logic               rst,
  fifo_wr_arbiter_if.master bus
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [3:0]      burst_cnt_q, burst_cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [PW-1:0]     pick_off;
  logic [PW:0]       pick_sum;
  logic [PW-1:0]     pick;

  logic          own_req;
  logic [DW-1:0] own_data;
  logic          wr;

  // Rotate requests so bit 0 is the producer at rr_ptr; lowest set bit is the winner.
  always_comb begin
    req_dbl  = {bus.req, bus.req} >> rr_ptr_q;
    req_rot  = req_dbl[NREQ-1:0];
    pick_off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) pick_off = PW'(k);
    end
    pick_sum = {1'b0, rr_ptr_q} + {1'b0, pick_off};
    pick     = (pick_sum >= (PW+1)'(NREQ)) ? PW'(pick_sum - (PW+1)'(NREQ)) : pick_sum[PW-1:0];
  end

  // Owner mux keyed off the one-hot grant, so all outputs fall to zero when idle.
  always_comb begin
    own_req  = 1'b0;
    own_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) begin
        own_req  = bus.req[i];
        own_data = bus.req_data[i*DW +: DW];
      end
    end
    wr = (state_q == StBurst) & own_req & ~bus.fifo_full;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    gnt_d       = gnt_q;
    unique case (state_q)
      StIdle: begin
        if (|bus.req) begin
          owner_d     = pick;
          gnt_d       = NREQ'(1'b1) << pick;
          burst_cnt_d = '0;
          state_d     = StBurst;
        end
      end
      StBurst: begin
        if (wr) burst_cnt_d = burst_cnt_q + 4'd1;
        if ((wr && (burst_cnt_q == 4'(MAX_BURST - 1))) || !own_req) begin
          gnt_d    = '0;
          rr_ptr_d = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      gnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      gnt_q       <= gnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.ack       = gnt_q & {NREQ{wr}};
  assign bus.fifo_we   = wr;
  assign bus.fifo_data = own_data;
  assign bus.busy      = (state_q == StBurst);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter: a cycle-level reference model feeds a scoreboard of
// expected outputs and written words, checked by an independent negedge monitor.
module tb_fifo_wr_arbiter;
  localparam int NREQ      = 4;
  localparam int DW        = 8;
  localparam int MAX_BURST = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] ack;
    logic            we;
    logic            busy;
    logic [DW-1:0]   data;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] word_q[$];
  int            vectors     = 0;
  int            miscompares = 0;

  // Producer stimulus state
  logic [DW-1:0] pq[NREQ][$];
  bit            pause[NREQ];
  bit            allow_pause = 0;
  bit            refill      = 0;

  // Reference model: idle/burst flag, owner, words written in burst, next-to-scan pointer
  bit m_busy  = 0;
  int m_owner = 0;
  int m_count = 0;
  int m_ptr   = 0;
  bit cur_wr  = 0;
  int cur_own = 0;

  exp_t          mon_e;
  logic [DW-1:0] mon_w;
  int            cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      vectors++;
      if (bus.gnt !== mon_e.gnt || bus.ack !== mon_e.ack || bus.fifo_we !== mon_e.we ||
          bus.busy !== mon_e.busy || bus.fifo_data !== mon_e.data) begin
        miscompares++;
        $display("FAIL outputs cyc=%0d got gnt=%b ack=%b we=%b busy=%b data=%h want gnt=%b ack=%b we=%b busy=%b data=%h",
                 cyc, bus.gnt, bus.ack, bus.fifo_we, bus.busy, bus.fifo_data,
                 mon_e.gnt, mon_e.ack, mon_e.we, mon_e.busy, mon_e.data);
      end
    end
    if (bus.fifo_we === 1'b1) begin
      vectors++;
      if (word_q.size() == 0) begin
        miscompares++;
        $display("FAIL word cyc=%0d got unexpected write data=%h want no write", cyc,
                 bus.fifo_data);
      end else begin
        mon_w = word_q.pop_front();
        if (bus.fifo_data !== mon_w) begin
          miscompares++;
          $display("FAIL word cyc=%0d got data=%h want %h", cyc, bus.fifo_data, mon_w);
        end
      end
    end
  end

  // Advance producers and the model across one clock edge, using the pre-edge inputs.
  task automatic model_edge();
    for (int i = 0; i < NREQ; i++) begin
      bit acked;
      acked = cur_wr && (cur_own == i);
      if (acked) void'(pq[i].pop_front());
      if (allow_pause && (acked || !bus.req[i])) pause[i] = ($urandom_range(0, 3) == 0);
      else if (!allow_pause) pause[i] = 0;
      if (refill && pq[i].size() < 3 && $urandom_range(0, 2) == 0)
        pq[i].push_back(DW'($urandom));
    end
    if (rst) begin
      m_busy  = 0;
      m_ptr   = 0;
      m_count = 0;
      m_owner = 0;
    end else if (!m_busy) begin
      if (bus.req != '0) begin
        bit found;
        found = 0;
        for (int k = 0; k < NREQ; k++) begin
          if (!found && bus.req[(m_ptr + k) % NREQ]) begin
            m_owner = (m_ptr + k) % NREQ;
            found   = 1;
          end
        end
        m_busy  = 1;
        m_count = 0;
      end
    end else begin
      if (cur_wr) m_count++;
      if (m_count == MAX_BURST || !bus.req[m_owner]) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % NREQ;
      end
    end
  endtask

  task automatic model_outputs();
    exp_t e;
    e      = '{gnt: '0, ack: '0, we: 1'b0, busy: 1'b0, data: '0};
    cur_wr = 0;
    if (m_busy) begin
      e.busy = 1'b1;
      e.gnt  = NREQ'(1) << m_owner;
      e.data = (pq[m_owner].size() > 0) ? pq[m_owner][0] : '0;
      cur_wr = bus.req[m_owner] && !bus.fifo_full;
      e.we   = cur_wr;
      if (cur_wr) begin
        e.ack = e.gnt;
        word_q.push_back(e.data);
      end
    end
    cur_own = m_owner;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic r, input logic full);
    @(posedge clk);
    model_edge();
    #1;
    rst           = r;
    bus.fifo_full = full;
    for (int i = 0; i < NREQ; i++) begin
      bus.req[i]                = (pq[i].size() > 0) && !pause[i];
      bus.req_data[i*DW +: DW]  = (pq[i].size() > 0) ? pq[i][0] : '0;
    end
    model_outputs();
  endtask

  function automatic bit all_idle();
    bit idle;
    idle = !m_busy;
    for (int i = 0; i < NREQ; i++) if (pq[i].size() > 0) idle = 0;
    return idle;
  endfunction

  initial begin
    bus.req       = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    for (int i = 0; i < NREQ; i++) pause[i] = 0;

    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    // Single producer with two bursts' worth of words
    for (int n = 0; n < 8; n++) pq[0].push_back(DW'(8'h10 + n));
    for (int c = 0; c < 16; c++) step(1'b0, 1'b0);
    // All producers requesting: full rotation
    for (int i = 0; i < NREQ; i++)
      for (int n = 0; n < 5; n++) pq[i].push_back(DW'((i << 4) | n));
    for (int c = 0; c < 30; c++) step(1'b0, 1'b0);
    // Stall window in the middle of a burst
    for (int n = 0; n < 4; n++) pq[1].push_back(DW'(8'hA0 + n));
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int c = 0; c < 3; c++) step(1'b0, 1'b1);
    for (int c = 0; c < 6; c++) step(1'b0, 1'b0);
    // Reset mid-burst
    for (int n = 0; n < 6; n++) pq[2].push_back(DW'(8'hC0 + n));
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int c = 0; c < 8; c++) step(1'b0, 1'b0);
    // Randomized traffic with pauses, full stalls and occasional resets
    allow_pause = 1;
    refill      = 1;
    for (int c = 0; c < 3000; c++)
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0));
    allow_pause = 0;
    refill      = 0;
    for (int c = 0; c < 400 && !all_idle(); c++) step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL exp_drain got %0d pending want 0", exp_q.size());
    end
    vectors++;
    if (word_q.size() != 0) begin
      miscompares++;
      $display("FAIL word_drain got %0d unwritten words want 0", word_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
